// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared geometry constants, state type and address helper for the Sobel accelerator
package acc_pkg;

    localparam logic [6:0]  IMG_W_WORDS = 7'd88;
    localparam logic [8:0]  IMG_H       = 9'd288;
    localparam logic [15:0] SRC_BASE    = 16'd0;
    localparam logic [15:0] DST_BASE    = 16'd25344;

    typedef enum logic [2:0] {
        IDLE,
        ZERO_ROW,
        LOAD,
        SHIFT_READ,
        COMPUTE,
        WRITE,
        DONE
    } state_t;

    // Word address of (row, col) inside an image region starting at base.
    function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [6:0] w_words,
                                              input logic [8:0] row, input logic [6:0] col);
        return base + 16'(row) * 16'(w_words) + 16'(col);
    endfunction

endpackage

// File: rtl/sobel_px.sv
// rtl/sobel_px.sv - one Sobel output pixel from a 3x3 neighbourhood, saturated to 8 bits
module sobel_px (
    input  logic [7:0] p00,
    input  logic [7:0] p01,
    input  logic [7:0] p02,
    input  logic [7:0] p10,
    input  logic [7:0] p11,
    input  logic [7:0] p12,
    input  logic [7:0] p20,
    input  logic [7:0] p21,
    input  logic [7:0] p22,
    output logic [7:0] q
);

    logic [9:0]  right_sum, left_sum, bot_sum, top_sum;
    logic [10:0] gx, gy, abs_gx, abs_gy, mag;
    logic        center_unused;

    // The centre tap has zero weight in both kernels.
    assign center_unused = ^p11;

    assign right_sum = {2'b00, p02} + {1'b0, p12, 1'b0} + {2'b00, p22};
    assign left_sum  = {2'b00, p00} + {1'b0, p10, 1'b0} + {2'b00, p20};
    assign bot_sum   = {2'b00, p20} + {1'b0, p21, 1'b0} + {2'b00, p22};
    assign top_sum   = {2'b00, p00} + {1'b0, p01, 1'b0} + {2'b00, p02};

    // Two's complement differences in 11 bits; |G| never exceeds 1020 so the sum fits without wrap.
    assign gx     = {1'b0, right_sum} - {1'b0, left_sum};
    assign gy     = {1'b0, bot_sum} - {1'b0, top_sum};
    assign abs_gx = gx[10] ? (~gx + 11'd1) : gx;
    assign abs_gy = gy[10] ? (~gy + 11'd1) : gy;
    assign mag    = abs_gx + abs_gy;
    assign q      = (mag > 11'd255) ? 8'hFF : mag[7:0];

endmodule

// File: rtl/acc_sobel.sv
// rtl/acc_sobel.sv - Sobel edge filter over a word-packed image with a 3x3-word sliding window
module acc_sobel
    import acc_pkg::*;
#(
    parameter logic [6:0]  W_WORDS = IMG_W_WORDS,
    parameter logic [8:0]  H_ROWS  = IMG_H,
    parameter logic [15:0] SRC     = SRC_BASE,
    parameter logic [15:0] DST     = DST_BASE
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] addr,
    input  logic [31:0] dataR,
    output logic [31:0] dataW,
    output logic        en,
    output logic        we,
    input  logic        start,
    output logic        finish
);

    localparam logic [6:0] LAST_COL = W_WORDS - 7'd1;
    localparam logic [8:0] LAST_ROW = H_ROWS - 9'd1;

    state_t      state, next_state;
    logic [8:0]  row;
    logic [6:0]  col;
    logic [2:0]  k;
    logic [2:0]  k_prev;
    logic [7:0]  prev_b [3];
    logic [31:0] cur_w  [3];
    logic [31:0] nxt_w  [3];
    logic [47:0] row_v  [3];
    logic [31:0] px_word, masked, result;
    logic [8:0]  src_row;
    logic [6:0]  src_col;

    assign k_prev  = k - 3'd1;
    assign src_row = row - 9'd1 + ((state == LOAD) ? {7'd0, k[2:1]} : {7'd0, k[1:0]});
    assign src_col = (state == LOAD) ? {6'd0, k[0]} : col + 7'd1;

    // Only the top byte of the previous word and the bottom byte of the next word are neighbours.
    for (genvar i = 0; i < 3; i++) begin : g_row
        assign row_v[i] = {nxt_w[i][7:0], cur_w[i], prev_b[i]};
    end

    for (genvar p = 0; p < 4; p++) begin : g_px
        sobel_px u_px (
            .p00(row_v[0][8*p +: 8]), .p01(row_v[0][8*p+8 +: 8]), .p02(row_v[0][8*p+16 +: 8]),
            .p10(row_v[1][8*p +: 8]), .p11(row_v[1][8*p+8 +: 8]), .p12(row_v[1][8*p+16 +: 8]),
            .p20(row_v[2][8*p +: 8]), .p21(row_v[2][8*p+8 +: 8]), .p22(row_v[2][8*p+16 +: 8]),
            .q  (px_word[8*p +: 8])
        );
    end

    // Force the image's left and right border columns to zero.
    always_comb begin
        masked = px_word;
        if (col == 7'd0)     masked[7:0]   = 8'h00;
        if (col == LAST_COL) masked[31:24] = 8'h00;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state decode and memory request generation.
    always_comb begin
        next_state = state;
        addr       = 16'd0;
        dataW      = 32'd0;
        en         = 1'b0;
        we         = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: if (start) next_state = ZERO_ROW;
            ZERO_ROW: begin
                en   = 1'b1;
                we   = 1'b1;
                addr = word_addr(DST, W_WORDS, row, col);
                if (col == LAST_COL) next_state = (row == 9'd0) ? LOAD : DONE;
            end
            LOAD: begin
                if (k < 3'd6) begin
                    en   = 1'b1;
                    addr = word_addr(SRC, W_WORDS, src_row, src_col);
                end else begin
                    next_state = COMPUTE;
                end
            end
            SHIFT_READ: begin
                if (col == LAST_COL || k == 3'd3) begin
                    next_state = COMPUTE;
                end else begin
                    en   = 1'b1;
                    addr = word_addr(SRC, W_WORDS, src_row, src_col);
                end
            end
            COMPUTE: next_state = WRITE;
            WRITE: begin
                en    = 1'b1;
                we    = 1'b1;
                addr  = word_addr(DST, W_WORDS, row, col);
                dataW = result;
                if (col != LAST_COL)            next_state = SHIFT_READ;
                else if (row == LAST_ROW - 9'd1) next_state = ZERO_ROW;
                else                            next_state = LOAD;
            end
            DONE: begin
                finish = 1'b1;
                if (!start) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Row/word counters, read-capture sequencing and the sliding window.
    always_ff @(posedge clk) begin
        if (!reset || state == IDLE) begin
            row    <= 9'd0;
            col    <= 7'd0;
            k      <= 3'd0;
            result <= 32'd0;
            for (int i = 0; i < 3; i++) begin
                prev_b[i] <= 8'd0;
                cur_w[i]  <= 32'd0;
                nxt_w[i]  <= 32'd0;
            end
        end else begin
            case (state)
                ZERO_ROW: begin
                    if (col == LAST_COL) begin
                        col <= 7'd0;
                        k   <= 3'd0;
                        if (row == 9'd0) row <= 9'd1;
                    end else begin
                        col <= col + 7'd1;
                    end
                end
                LOAD: begin
                    k <= k + 3'd1;
                    if (k != 3'd0) begin
                        if (k_prev[0]) nxt_w[k_prev[2:1]] <= dataR;
                        else           cur_w[k_prev[2:1]] <= dataR;
                    end
                end
                SHIFT_READ: begin
                    if (col != LAST_COL) begin
                        k <= k + 3'd1;
                        if (k != 3'd0) nxt_w[k_prev[1:0]] <= dataR;
                    end
                end
                COMPUTE: begin
                    result <= masked;
                    k      <= 3'd0;
                end
                WRITE: begin
                    k <= 3'd0;
                    if (col != LAST_COL) begin
                        col <= col + 7'd1;
                        for (int i = 0; i < 3; i++) begin
                            prev_b[i] <= cur_w[i][31:24];
                            cur_w[i]  <= nxt_w[i];
                            nxt_w[i]  <= 32'd0;
                        end
                    end else begin
                        col <= 7'd0;
                        row <= row + 9'd1;
                        for (int i = 0; i < 3; i++) begin
                            prev_b[i] <= 8'd0;
                            cur_w[i]  <= 32'd0;
                            nxt_w[i]  <= 32'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_sobel.sv
// tb/tb_acc_sobel.sv - directed self-checking bench for acc_sobel on a reduced image geometry
`timescale 1ns/1ps
module tb_acc_sobel;

    localparam int W         = 8;
    localparam int H         = 16;
    localparam int COLS      = 4 * W;
    localparam int DST       = 25344;
    localparam int NWORDS    = W * H;
    localparam int EXP_READS = (H - 2) * (6 + 3 * (W - 2));

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        en, we, finish;
    logic [15:0] addr;
    logic [31:0] dataR = 32'd0;
    logic [31:0] dataW;

    acc_sobel #(
        .W_WORDS(7'(W)),
        .H_ROWS (9'(H)),
        .SRC    (16'd0),
        .DST    (16'(DST))
    ) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .dataR (dataR),
        .dataW (dataW),
        .en    (en),
        .we    (we),
        .start (start),
        .finish(finish)
    );

    always #5 clk = ~clk;

    logic [7:0]  img     [H][COLS];
    logic [31:0] src_mem [NWORDS];
    logic [31:0] res     [NWORDS];
    int checks = 0;
    int errors = 0;
    int wr_idx = 0;
    int rd_cnt = 0;
    bit monitor_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int pix(input int r, input int x);
        return int'(img[r][x]);
    endfunction

    // Reference result word computed directly from the image and the Sobel definition.
    function automatic logic [31:0] exp_word(input int r, input int c);
        logic [31:0] w;
        int x, gx, gy, m;
        w = 32'd0;
        if (r == 0 || r == H - 1) return w;
        for (int p = 0; p < 4; p++) begin
            x = 4 * c + p;
            if (x == 0 || x == COLS - 1) continue;
            gx = (pix(r-1, x+1) + 2*pix(r, x+1) + pix(r+1, x+1))
               - (pix(r-1, x-1) + 2*pix(r, x-1) + pix(r+1, x-1));
            gy = (pix(r+1, x-1) + 2*pix(r+1, x) + pix(r+1, x+1))
               - (pix(r-1, x-1) + 2*pix(r-1, x) + pix(r-1, x+1));
            m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            if (m > 255) m = 255;
            w[8*p +: 8] = 8'(m);
        end
        return w;
    endfunction

    task automatic make_image(input int mode);
        for (int r = 0; r < H; r++) begin
            for (int x = 0; x < COLS; x++) begin
                case (mode)
                    0:       img[r][x] = 8'h80;
                    1:       img[r][x] = (x < COLS / 2) ? 8'h00 : 8'hFF;
                    2:       img[r][x] = (r < H / 2) ? 8'h00 : 8'hFF;
                    default: img[r][x] = (r == 10 && x == 10) ? 8'h28 : 8'h00;
                endcase
            end
        end
        for (int w = 0; w < NWORDS; w++) begin
            src_mem[w] = {img[w / W][4*(w % W) + 3], img[w / W][4*(w % W) + 2],
                          img[w / W][4*(w % W) + 1], img[w / W][4*(w % W)]};
        end
    endtask

    // Image memory: read data appears the cycle after the request.
    always @(posedge clk) begin
        if (en && !we) dataR <= (int'(addr) < NWORDS) ? src_mem[addr] : 32'hDEADBEEF;
    end

    // Compare process: every write against the reference, every read inside the source image.
    initial begin
        forever begin
            @(negedge clk);
            if (monitor_on) begin
                if (en && we) begin
                    if (wr_idx >= NWORDS) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_write: addr %h beyond %0d result words", addr, NWORDS);
                    end else begin
                        check("wr_addr", {16'd0, addr}, 32'(DST + wr_idx));
                        check("wr_data", dataW, exp_word(wr_idx / W, wr_idx % W));
                        res[wr_idx] = dataW;
                        wr_idx++;
                    end
                end else if (en) begin
                    check("rd_in_src", 32'(int'(addr) < NWORDS), 32'd1);
                    rd_cnt++;
                end else begin
                    check("idle_dataW", dataW, 32'd0);
                end
            end
        end
    end

    task automatic wait_finish(input string tag);
        int n;
        n = 0;
        while (finish !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_finish_seen"}, {31'd0, finish}, 32'd1);
    endtask

    task automatic run_image(input int mode, input bit drop_start, input string tag);
        make_image(mode);
        wr_idx = 0;
        rd_cnt = 0;
        @(posedge clk);
        #1 start = 1'b1;
        if (drop_start) begin
            repeat (50) @(posedge clk);
            #1 start = 1'b0;
        end
        wait_finish(tag);
        check({tag, "_write_count"}, wr_idx, NWORDS);
        check({tag, "_read_count"}, rd_cnt, EXP_READS);
    endtask

    task automatic release_start(input string tag);
        if (start) begin
            @(posedge clk);
            #1 start = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, "_finish_clears"}, {31'd0, finish}, 32'd0);
    endtask

    initial begin
        int bad;
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_addr", {16'd0, addr}, 32'd0);
        check("rst_dataW", dataW, 32'd0);
        check("rst_en_we_fin", {29'd0, en, we, finish}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        monitor_on = 1'b1;

        // Flat image, then start held high in DONE.
        run_image(0, 1'b0, "flat");
        check("flat_first", res[0], 32'h0);
        check("flat_mid", res[5*W + 4], 32'h0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (finish !== 1'b1 || en !== 1'b0) bad++;
        end
        check("hold_done", bad, 0);
        release_start("flat");

        // Vertical edge; start dropped mid-run must be ignored.
        run_image(1, 1'b1, "vert");
        check("vert_w3", res[5*W + 3], 32'hFF000000);
        check("vert_w4", res[5*W + 4], 32'h000000FF);
        check("vert_row0", res[3], 32'h0);
        check("vert_lastrow", res[(H-1)*W + 4], 32'h0);
        release_start("vert");

        // Horizontal edge between rows 7 and 8.
        run_image(2, 1'b0, "horz");
        check("horz_r7_w0", res[7*W], 32'hFFFFFF00);
        check("horz_r7_w3", res[7*W + 3], 32'hFFFFFFFF);
        check("horz_r8_wl", res[8*W + W - 1], 32'h00FFFFFF);
        check("horz_r6", res[6*W + 3], 32'h0);
        check("horz_r9", res[9*W + 3], 32'h0);
        release_start("horz");

        // Single 0x28 pixel at (10, 10).
        run_image(3, 1'b0, "dot");
        check("dot_r9", res[9*W + 2], 32'h50505000);
        check("dot_r10", res[10*W + 2], 32'h50005000);
        check("dot_r11", res[11*W + 2], 32'h50505000);
        check("dot_r10_w1", res[10*W + 1], 32'h0);
        check("dot_r10_w3", res[10*W + 3], 32'h0);
        release_start("dot");

        // One-cycle reset mid-run, then a full rerun.
        make_image(0);
        wr_idx = 0;
        rd_cnt = 0;
        @(posedge clk);
        #1 start = 1'b1;
        repeat (300) @(posedge clk);
        #1 begin
            reset = 1'b0;
            start = 1'b0;
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("midrst_en_we_fin", {29'd0, en, we, finish}, 32'd0);
        check("midrst_addr", {16'd0, addr}, 32'd0);
        check("midrst_dataW", dataW, 32'd0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (en !== 1'b0) bad++;
        end
        check("midrst_quiet", bad, 0);
        run_image(0, 1'b0, "rerun");
        check("rerun_last", res[NWORDS - 1], 32'h0);
        release_start("rerun");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_sobel.md
ACC_SOBEL -- requirements
Module: acc_sobel

Interface
REQ-001 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 Port reset, input, 1: synchronous, active-low reset; sampled only on rising clk edge.
REQ-003 Port addr, output, 16: word address to image memory.
REQ-004 Port dataR, input, 32: read data, valid the cycle after a read request.
REQ-005 Port dataW, output, 32: write data, valid with en=1, we=1.
REQ-006 Port en, output, 1: memory request.
REQ-007 Port we, output, 1: 1 = write, 0 = read; meaningful only with en=1.
REQ-008 Port start, input, 1: level request to begin processing.
REQ-009 Port finish, output, 1: processing complete.

Function
REQ-010 Image 352x288 8-bit pixels, 88 words/row, 4 pixels/word; lowest column in dataR[7:0], highest in [31:24].
REQ-011 Source words 0..25343; result words 25344..50687; row r, word c at base + 88*r + c.
REQ-012 Read protocol: en=1, we=0, addr driven in cycle N; dataR captured in cycle N+1; at most one request per cycle.
REQ-013 Write protocol: en=1, we=1, addr, dataW driven in one cycle; no response expected.
REQ-014 Output pixel = min(|Gx|+|Gy|, 255); Gx = right column (1,2,1) minus left column (1,2,1); Gy = bottom row (1,2,1) minus top row (1,2,1).
REQ-015 Gx, Gy computed as 11-bit signed, magnitude sum 11-bit unsigned, saturated to 8 bits; no wrap.
REQ-016 Border pixels (row 0, row 287, column 0, column 351) SHALL be written as 0x00.
REQ-017 Rows 0 and 287 SHALL be written as 88 zero words without any reads.
REQ-018 Interior rows: sliding window of 3 rows x 3 words (prev, cur, next); row start loads words 0 and 1 of rows r-1, r, r+1 (6 reads); each step computes 4 pixels of word c, writes it, shifts window, reads word c+2 of the 3 rows (3 reads) when c+2 <= 87.
REQ-019 Word 0 uses prev = 0 (unused, border); word 87 uses next = 0 (unused, border).
REQ-020 States: IDLE, ZERO_ROW, LOAD, SHIFT_READ, COMPUTE, WRITE, DONE.
REQ-021 IDLE -> ZERO_ROW on start=1 (row 0); ZERO_ROW -> LOAD after 88 writes of row 0; LOAD -> COMPUTE; COMPUTE -> WRITE; WRITE -> SHIFT_READ if c<87, else LOAD for next interior row or ZERO_ROW for row 287; SHIFT_READ -> COMPUTE; ZERO_ROW(row 287) -> DONE.
REQ-022 Every result word SHALL be written exactly once, in ascending address order.
REQ-023 DONE: finish=1, en=0; return to IDLE when start=0; start held high SHALL NOT restart.
REQ-024 start changes while not in IDLE/DONE SHALL be ignored.
REQ-025 en=0 and dataW=0 in every cycle with no request.

Reset
REQ-026 reset=0 at a clock edge SHALL force IDLE, addr=0, dataW=0, en=0, we=0, finish=0, counters and window cleared, in the following cycle.
REQ-027 Reset mid-operation SHALL abandon the run with no further memory access; a later start SHALL rerun the full image.

Structure
REQ-028 Package acc_pkg SHALL hold IMG_W_WORDS=88, IMG_H=288, SRC_BASE=0, DST_BASE=25344 and the state enum type.
REQ-029 Sub-module sobel_px (combinational, nine 8-bit inputs -> one 8-bit output) SHALL be instantiated 4 times.
REQ-030 Address arithmetic SHALL be 16-bit unsigned; row/word counters sized 9 and 7 bits.

Verification
REQ-031 All pixels 0x80 -> 25344 writes to 25344..50687, each once, all 0x00000000; then finish=1.
REQ-032 Columns 0..175 = 0x00, 176..351 = 0xFF -> interior rows: word 43 = 0xFF000000, word 44 = 0x000000FF, all others 0; rows 0/287 zero.
REQ-033 Rows 0..100 = 0x00, 101..287 = 0xFF -> rows 100 and 101: word 0 = 0xFFFFFF00, words 1..86 = 0xFFFFFFFF, word 87 = 0x00FFFFFF; other rows 0.
REQ-034 Single pixel 0x28 at (row 10, col 10), rest 0 -> rows 9 and 11 word 2 = 0x50505000; row 10 word 2 = 0x50005000; all else 0.
REQ-035 reset=0 for one cycle 1000 cycles after start -> en=0, we=0, finish=0 next cycle; restart produces REQ-031 result exactly.
REQ-036 start held high after finish -> finish stays 1, en stays 0; start=0 -> IDLE, finish=0 next cycle.
